// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   Start, Op         launch request and operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   RsData, RtData    operands; RsData also carries MTHI/MTLO data
//   HiWrite, LoWrite  MTHI / MTLO strobes, honoured only while idle
//   Busy              operation in flight, CPU must stall
//   Done              one-cycle pulse, Hi/Lo just updated
//   Hi, Lo            HI/LO architectural registers
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] RsData,
    input  logic [WIDTH-1:0] RtData,
    input  logic             HiWrite,
    input  logic             LoWrite,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            fix_ph;     // FIX spans two cycles: sign fix-up, then HI/LO write
    logic            is_div;
    logic            sign_a;
    logic            sign_b;
    logic            div_zero;
    logic [WIDTH-1:0] opnd;      // multiplicand (mult) or divisor (div), already abs'd
    logic [AW-1:0]   acc;        // mult: {partial, multiplier}; div: {remainder, quotient}

    logic            start_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [AW-1:0]   step_acc;
    logic [AW-1:0]   fix_acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (Start) state_nx = CALC;
            CALC: if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:  if (fix_ph) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand conditioning at launch: magnitudes only for the signed ops
    always_comb begin
        start_signed = Op[0];
        abs_a        = (start_signed && RsData[WIDTH-1]) ? (~RsData + WIDTH'(1)) : RsData;
        abs_b        = (start_signed && RtData[WIDTH-1]) ? (~RtData + WIDTH'(1)) : RtData;
    end

    // One radix-2 iteration: shift-add multiply or restoring divide
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        step_acc = acc;
        if (is_div) begin
            shifted = {acc[AW-1:WIDTH], acc[WIDTH-1]};
            diff    = shifted - {1'b0, opnd};
            if (!diff[WIDTH]) begin
                step_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum      = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
            step_acc = {sum, acc[WIDTH-1:1]};
        end
    end

    // Sign restoration; divide-by-zero forces an all-ones quotient
    always_comb begin
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] rem;
        quo     = acc[WIDTH-1:0];
        rem     = acc[AW-1:WIDTH];
        fix_acc = acc;
        if (is_div) begin
            if (div_zero) begin
                quo = '1;
            end else if (sign_a ^ sign_b) begin
                quo = ~quo + WIDTH'(1);
            end
            if (sign_a) begin
                rem = ~rem + WIDTH'(1);
            end
            fix_acc = {rem, quo};
        end else if (sign_a ^ sign_b) begin
            fix_acc = ~acc + AW'(1);
        end
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            fix_ph   <= 1'b0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            Hi       <= '0;
            Lo       <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (HiWrite) Hi <= RsData;
                    if (LoWrite) Lo <= RsData;
                    if (Start) begin
                        is_div   <= Op[1];
                        sign_a   <= start_signed && RsData[WIDTH-1];
                        sign_b   <= start_signed && RtData[WIDTH-1];
                        div_zero <= (RtData == '0);
                        opnd     <= Op[1] ? abs_b : abs_a;
                        acc      <= {{WIDTH{1'b0}}, (Op[1] ? abs_a : abs_b)};
                        cnt      <= '0;
                        fix_ph   <= 1'b0;
                        Busy     <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (!fix_ph) begin
                        acc    <= fix_acc;
                        fix_ph <= 1'b1;
                    end else begin
                        Hi     <= acc[AW-1:WIDTH];
                        Lo     <= acc[WIDTH-1:0];
                        fix_ph <= 1'b0;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                    end
                end
                default: begin
                    Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
